// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants: sequencer states, PC increments, default boot address.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    localparam int INC_WORD = 4;
    localparam int INC_HALF = 2;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    // Low PC bits that must be zero: halfword alignment with compressed ISA, word alignment otherwise.
    function automatic logic [1:0] align_mask(input bit c_ext);
        return c_ext ? 2'b01 : 2'b11;
    endfunction

endpackage

// File: rtl/pc_adder.sv
// Sequential-PC adder: sum = pc + inc, wrapping modulo 2^XLEN.
// Latency: combinational.
// Backpressure: none.
module pc_adder #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [2:0]      inc,
    output logic [XLEN-1:0] sum
);

    // Zero-extend the small increment; carry out of the top bit is dropped on purpose.
    assign sum = pc + {{(XLEN-3){1'b0}}, inc};

endmodule

// File: rtl/pc_sequencer.sv
// IF-stage PC sequencer: holds fetch PC, arbitrates trap > branch > sequential next-PC, halt/resume control.
// Latency: one cycle from redirect/handshake to new pc_o; one BOOT cycle after reset before the first fetch.
// Backpressure: pc_o holds while fetch_ready_i or stall_i withholds the advance; redirects override both.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter bit              C_EXT        = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            br_valid_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            halt_i,
    input  logic            resume_i,
    input  logic            is_comp_i,
    input  logic            fetch_ready_i,
    output logic            fetch_valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus_o,
    output logic            misalign_o,
    output logic            halted_o
);

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b0}}, align_mask(C_EXT)};

    pc_state_e       state_q;
    logic [2:0]      inc;
    logic            redir_vld;
    logic [XLEN-1:0] redir_tgt;
    logic            redir_mis;
    logic [XLEN-1:0] redir_pc;
    logic            seq_adv;

    // Halfword step only when the compressed ISA is built in and the current fetch is 16-bit.
    assign inc = (C_EXT && is_comp_i) ? 3'(INC_HALF) : 3'(INC_WORD);

    pc_adder #(
        .XLEN (XLEN)
    ) u_pc_adder (
        .pc  (pc_o),
        .inc (inc),
        .sum (pc_plus_o)
    );

    // Trap beats branch; a losing branch is dropped, so only the winner's alignment is judged.
    assign redir_vld = trap_valid_i | br_valid_i;
    assign redir_tgt = trap_valid_i ? trap_vec_i : br_target_i;
    assign redir_mis = |(redir_tgt & ALIGN_MASK);
    assign redir_pc  = redir_tgt & ~ALIGN_MASK;

    // Sequential advance only on a completed, unstalled handshake in RUN.
    assign seq_adv = (state_q == RUN) & fetch_valid_o & fetch_ready_i & ~stall_i;

    // PC register, misalign pulse and BOOT/RUN/HALT control with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_o          <= RESET_VECTOR;
            fetch_valid_o <= 1'b0;
            halted_o      <= 1'b0;
            misalign_o    <= 1'b0;
        end else begin
            misalign_o <= redir_vld & redir_mis;

            if (redir_vld) begin
                pc_o <= redir_pc;
            end else if (seq_adv) begin
                pc_o <= pc_plus_o;
            end

            case (state_q)
                BOOT: begin
                    state_q       <= RUN;
                    fetch_valid_o <= 1'b1;
                    halted_o      <= 1'b0;
                end
                RUN: begin
                    // A trap in the same cycle keeps the core running at the trap vector.
                    if (halt_i && !trap_valid_i) begin
                        state_q       <= HALT;
                        fetch_valid_o <= 1'b0;
                        halted_o      <= 1'b1;
                    end
                end
                HALT: begin
                    // resume_i outranks a concurrent halt_i; a trap also wakes the core.
                    if (resume_i || trap_valid_i) begin
                        state_q       <= RUN;
                        fetch_valid_o <= 1'b1;
                        halted_o      <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= BOOT;
                    fetch_valid_o <= 1'b0;
                    halted_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: word-only instance u0 feeds a fetch scoreboard, compressed instance u1 is spot-checked.
// Latency: n/a.
// Backpressure: fetch_ready toggled by the stimulus to exercise holds.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, br_v, trap_v, halt, resume, comp, ready;
    logic [31:0] br_t, trap_t;

    logic        fv0, mis0, h0;
    logic [31:0] pc0, pcp0;
    logic        fv1, mis1, h1;
    logic [31:0] pc1, pcp1;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] expq[$];
    logic [31:0] mon_exp;

    always #5 clk = ~clk;

    pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h100), .C_EXT(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall),
        .br_valid_i(br_v), .br_target_i(br_t),
        .trap_valid_i(trap_v), .trap_vec_i(trap_t),
        .halt_i(halt), .resume_i(resume), .is_comp_i(comp),
        .fetch_ready_i(ready), .fetch_valid_o(fv0), .pc_o(pc0),
        .pc_plus_o(pcp0), .misalign_o(mis0), .halted_o(h0)
    );

    pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h100), .C_EXT(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall),
        .br_valid_i(br_v), .br_target_i(br_t),
        .trap_valid_i(trap_v), .trap_vec_i(trap_t),
        .halt_i(halt), .resume_i(resume), .is_comp_i(comp),
        .fetch_ready_i(ready), .fetch_valid_o(fv1), .pc_o(pc1),
        .pc_plus_o(pcp1), .misalign_o(mis1), .halted_o(h1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // Monitor: every accepted fetch on u0 is compared against the next queued PC.
    always @(negedge clk) begin
        if (rst_n && fv0 && ready) begin
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL fetch_unexpected: got pc %h want no fetch", pc0);
            end else begin
                mon_exp = expq.pop_front();
                if (pc0 !== mon_exp) begin
                    bad++;
                    $display("FAIL fetch_pc: got %h want %h", pc0, mon_exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; br_v = 1'b0; trap_v = 1'b0;
        halt = 1'b0; resume = 1'b0; comp = 1'b0; ready = 1'b1;
        br_t = 32'h0; trap_t = 32'h0;

        // Reset values
        cyc(); cyc(); neg();
        chk("rst_pc", pc0, 32'h100);
        chk("rst_fv", {31'b0, fv0}, 32'h0);
        chk("rst_halted", {31'b0, h0}, 32'h0);
        chk("rst_mis", {31'b0, mis0}, 32'h0);
        chk("rst_pcplus", pcp0, 32'h104);

        // Boot cycle then three sequential fetches
        expq.push_back(32'h100); expq.push_back(32'h104); expq.push_back(32'h108);
        cyc(); rst_n = 1'b1;
        neg();
        chk("boot_fv", {31'b0, fv0}, 32'h0);
        chk("boot_pc", pc0, 32'h100);
        cyc(); cyc(); cyc(); cyc();
        ready = 1'b0; br_v = 1'b1; br_t = 32'h300;
        neg();
        chk("seq_pc", pc0, 32'h10C);

        // Memory not ready for three cycles: PC holds
        cyc(); br_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("hold_pc", pc0, 32'h300);
            cyc();
        end
        ready = 1'b1; expq.push_back(32'h300);
        neg();
        cyc(); ready = 1'b0; br_v = 1'b1; br_t = 32'hFFFF_FFFC;
        neg();
        chk("after_hold_pc", pc0, 32'h304);

        // Wrap at the top of the address space
        cyc(); br_v = 1'b0; ready = 1'b1; expq.push_back(32'hFFFF_FFFC);
        neg();
        chk("wrap_pcplus", pcp0, 32'h0);
        cyc(); ready = 1'b0; stall = 1'b1;
        br_v = 1'b1; br_t = 32'h400; trap_v = 1'b1; trap_t = 32'h80;
        neg();
        chk("wrap_pc", pc0, 32'h0);

        // Trap beats branch under stall; then branch alone beats stall
        cyc(); trap_v = 1'b0;
        neg();
        chk("trap_pc", pc0, 32'h80);
        chk("trap_mis", {31'b0, mis0}, 32'h0);
        chk("trap_fv", {31'b0, fv0}, 32'h1);
        cyc(); stall = 1'b0; br_t = 32'h1006;
        neg();
        chk("br_stall_pc", pc0, 32'h400);
        chk("br_stall_mis", {31'b0, mis0}, 32'h0);

        // Misaligned branch: low bits cleared, one-cycle pulse
        cyc(); br_v = 1'b0;
        neg();
        chk("misal_pc", pc0, 32'h1004);
        chk("misal_pulse", {31'b0, mis0}, 32'h1);
        cyc(); br_v = 1'b1; br_t = 32'h1003; trap_v = 1'b1; trap_t = 32'h80;
        neg();
        chk("misal_clear", {31'b0, mis0}, 32'h0);

        // Misaligned branch losing to a trap: no pulse
        cyc(); trap_v = 1'b0; br_t = 32'h200;
        neg();
        chk("lose_pc", pc0, 32'h80);
        chk("lose_mis", {31'b0, mis0}, 32'h0);

        // Compressed increments on u1
        cyc(); br_v = 1'b0; comp = 1'b1; ready = 1'b1; expq.push_back(32'h200);
        neg();
        chk("c_pcplus_half", pcp1, 32'h202);
        cyc(); comp = 1'b0; expq.push_back(32'h204);
        neg();
        chk("c_pc_half", pc1, 32'h202);
        chk("c_pcplus_word", pcp1, 32'h206);
        cyc(); ready = 1'b0; halt = 1'b1;
        neg();
        chk("c_pc_word", pc1, 32'h206);
        chk("nc_pc", pc0, 32'h208);

        // Halt freezes the PC
        cyc(); halt = 1'b0; ready = 1'b1;
        neg();
        chk("halt_halted", {31'b0, h0}, 32'h1);
        chk("halt_fv", {31'b0, fv0}, 32'h0);
        cyc(); cyc();
        neg();
        chk("halt_pc", pc0, 32'h208);
        cyc(); resume = 1'b1; ready = 1'b0;
        cyc(); resume = 1'b0; halt = 1'b1;
        neg();
        chk("resume_halted", {31'b0, h0}, 32'h0);
        chk("resume_fv", {31'b0, fv0}, 32'h1);

        // Second halt, left by a trap
        cyc(); halt = 1'b0; trap_v = 1'b1; trap_t = 32'h90;
        neg();
        chk("halt2_halted", {31'b0, h0}, 32'h1);
        cyc(); trap_v = 1'b0; halt = 1'b1; ready = 1'b1; expq.push_back(32'h90);
        neg();
        chk("trapwake_halted", {31'b0, h0}, 32'h0);
        chk("trapwake_pc", pc0, 32'h90);

        // Halt on a completing handshake still advances; halt+resume in HALT resumes
        cyc(); ready = 1'b0; resume = 1'b1;
        neg();
        chk("halt_adv_halted", {31'b0, h0}, 32'h1);
        chk("halt_adv_pc", pc0, 32'h94);
        cyc(); halt = 1'b0; resume = 1'b0;
        neg();
        chk("resume_wins_halted", {31'b0, h0}, 32'h0);
        chk("resume_wins_fv", {31'b0, fv0}, 32'h1);

        // Asynchronous reset mid-stream
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pc", pc0, 32'h100);
        chk("arst_fv", {31'b0, fv0}, 32'h0);
        chk("arst_halted", {31'b0, h0}, 32'h0);
        chk("arst_pc_c", pc1, 32'h100);
        cyc(); rst_n = 1'b1;

        chk("queue_drained", 32'(expq.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer for the IF stage; the successor to the plain PC+4 adder.
- Holds the architectural fetch PC and computes the sequential increment (4, or 2 when compressed instructions are enabled).
- Arbitrates trap, branch and sequential next-PC sources.
- Presents the PC to instruction memory over a valid/ready handshake, with halt/resume control.

Parameters:
- XLEN, 32, PC and target width.
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- C_EXT, 0, 1 enables 2-byte increments and 2-byte alignment; 0 means 4-byte only.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- stall_i  in  1  hold PC (hazard unit).
- br_valid_i  in  1  branch/jump redirect request (from EX).
- br_target_i  in  XLEN  redirect target.
- trap_valid_i  in  1  trap/exception redirect request.
- trap_vec_i  in  XLEN  trap vector.
- halt_i  in  1  request halt.
- resume_i  in  1  leave halt.
- is_comp_i  in  1  current fetch is a 16-bit instruction; ignored when C_EXT=0.
- fetch_ready_i  in  1  instruction memory accepts the PC.
- fetch_valid_o  out  1  pc_o is a valid fetch request.
- pc_o  out  XLEN  current fetch PC.
- pc_plus_o  out  XLEN  pc_o + increment, for link-register writeback.
- misalign_o  out  1  one-cycle pulse: redirect target was misaligned.
- halted_o  out  1  sequencer is in HALT.

Behaviour:
- Reset (async, rst_n low):
  - pc_o = RESET_VECTOR; state = BOOT.
  - fetch_valid_o = 0, misalign_o = 0, halted_o = 0.
  - pc_plus_o is combinational from pc_o.
- States:
  - BOOT: exactly one cycle after rst_n deasserts, fetch_valid_o = 0, then go to RUN. Redirects that arrive in BOOT are still applied.
  - RUN: fetch_valid_o = 1.
  - HALT: fetch_valid_o = 0, halted_o = 1.
- Increment:
  - inc = 2 when C_EXT=1 and is_comp_i=1; otherwise inc = 4.
  - pc_plus_o = pc_o + inc, modulo 2^XLEN. 32'hFFFF_FFFC + 4 = 32'h0.
- Next-PC priority, evaluated each rising edge:
  - trap_valid_i: pc <= trap_vec_i.
  - else br_valid_i: pc <= br_target_i.
  - else in RUN, with fetch_valid_o & fetch_ready_i & !stall_i: pc <= pc_plus_o.
  - else: hold.
- Redirects:
  - Redirects override stall_i and !fetch_ready_i, and apply in any state.
  - A trap redirect also forces HALT to RUN.
- Handshake:
  - While fetch_valid_o=1 and fetch_ready_i=0, pc_o is held stable; sequential advance waits.
  - A redirect may replace pc_o mid-wait. Instruction memory must tolerate this.
- Alignment:
  - Alignment mask is 2'b11 when C_EXT=0, 2'b01 when C_EXT=1.
  - If (target & mask) != 0 on the accepted redirect: low bits are cleared before loading and misalign_o pulses for one cycle (registered).
  - A branch that loses to a trap produces no misalign pulse.
- Halt:
  - In RUN, halt_i moves to HALT at the next edge; the PC still advances on that edge if a handshake completes.
  - In HALT, resume_i returns to RUN. halt_i and resume_i together in HALT: resume wins.
- Simultaneous trap and branch: trap wins, branch is dropped (no buffering).
- Reset mid-operation: immediate return to the reset values above; no pending state survives.

Decomposition:
- Shared package cpu_pkg:
  - pc_state_e enum {BOOT, RUN, HALT}.
  - INC_WORD = 4, INC_HALF = 2.
  - Default RESET_VECTOR constant.
- Sub-module pc_adder: parametrised XLEN adder computing pc + inc. It supersedes the fixed +4 incrementer; everything else stays in pc_sequencer.

Test Plan:
- Reset release, RESET_VECTOR=32'h100, fetch_ready_i=1 → pc_o=32'h100 with fetch_valid_o=0 for one cycle; then 0x100, 0x104, 0x108 on consecutive cycles.
- C_EXT=1, pc=0x200, is_comp_i=1 then 0 → pc_plus_o=0x202, pc_o goes 0x202 then 0x206.
- stall_i=1 and br_valid_i=1 with br_target_i=0x400, plus trap_valid_i=1 with trap_vec_i=0x80 in the same cycle → pc_o=0x80, no misalign pulse. Repeat without the trap → pc_o=0x400 despite the stall.
- C_EXT=0, br_target_i=0x1006 → pc_o=0x1004, misalign_o high for exactly one cycle.
- fetch_ready_i=0 for 3 cycles at pc=0x300 → pc_o stable at 0x300; ready high → 0x304 next. Also pc=32'hFFFF_FFFC → next pc=0.
- halt_i pulse → halted_o=1, fetch_valid_o=0, PC frozen. resume_i → RUN. Second halt followed by trap → RUN at trap_vec_i. rst_n asserted mid-stream → pc_o=RESET_VECTOR immediately, asynchronously.
